// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared types and constants for the restoring divider
package pe_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pe_sub_step.sv
// rtl/pe_sub_step.sv - combinational trial subtraction for one restoring step
module pe_sub_step #(
    parameter int W = 9
) (
    input  logic [W-1:0] minuend,
    input  logic [W-1:0] subtrahend,
    output logic [W-1:0] diff,
    output logic         borrow
);

    // Extra MSB of the widened subtraction is the borrow out
    assign {borrow, diff} = {1'b0, minuend} - {1'b0, subtrahend};

endmodule

// File: rtl/pe_divider.sv
// rtl/pe_divider.sv - unsigned restoring divider, one quotient bit per cycle
module pe_divider
    import pe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] divisor_q;
    logic             zero_q;

    logic [WIDTH:0]   partial;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;
    logic             diff_msb_unused;

    // quo_q starts as the dividend and shifts left: its MSB feeds the partial
    // remainder while quotient bits enter at the LSB
    assign partial = {rem_q, quo_q[WIDTH-1]};

    pe_sub_step #(
        .W(WIDTH + 1)
    ) u_sub_step (
        .minuend   (partial),
        .subtrahend({1'b0, divisor_q}),
        .diff      (diff),
        .borrow    (borrow)
    );

    // A kept difference is always below the divisor, so its MSB is never needed
    assign diff_msb_unused = diff[WIDTH];
    assign rem_step        = borrow ? partial[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_step        = {quo_q[WIDTH-2:0], ~borrow};

    // FSM, step counter, shift/restore registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            count       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            divisor_q   <= '0;
            zero_q      <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        state     <= ST_CALC;
                        in_ready  <= 1'b0;
                        divisor_q <= divisor;
                        if (divisor == '0) begin
                            // No steps: the result is preloaded and emerges one edge later
                            zero_q <= 1'b1;
                            count  <= '0;
                            rem_q  <= dividend;
                            quo_q  <= '1;
                        end else begin
                            zero_q <= 1'b0;
                            count  <= CW'(WIDTH);
                            rem_q  <= '0;
                            quo_q  <= dividend;
                        end
                    end
                end
                ST_CALC: begin
                    if (count != '0) begin
                        rem_q <= rem_step;
                        quo_q <= quo_step;
                        count <= count - CW'(1);
                    end else begin
                        state       <= ST_DONE;
                        out_valid   <= 1'b1;
                        quotient    <= quo_q;
                        remainder   <= rem_q;
                        div_by_zero <= zero_q;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_divider.sv
// tb/tb_pe_divider.sv - self-checking bench for pe_divider
module tb_pe_divider;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int pass_cnt  = 0;
    int total_cnt = 0;

    int         r_lat;
    logic [7:0] r_q;
    logic [7:0] r_r;
    logic       r_z;
    bit         r_ok;

    logic [16:0] exp_q[$];

    always #5 clk = ~clk;

    pe_divider #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    function automatic logic [16:0] model(input logic [7:0] a, input logic [7:0] b);
        if (b == 8'd0) return {8'hFF, a, 1'b1};
        return {8'(a / b), 8'(a % b), 1'b0};
    endfunction

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit noise);
        int n;
        r_ok  = 1'b0;
        r_lat = -1;
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) begin
                r_lat    = k;
                r_q      = quotient;
                r_r      = remainder;
                r_z      = div_by_zero;
                r_ok     = 1'b1;
                in_valid = 1'b0;
                break;
            end
            if (noise) begin
                in_valid = 1'b1;
                dividend = 8'($urandom);
                divisor  = 8'($urandom);
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #12;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready);
        else pass_cnt++;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if ({quotient, remainder, div_by_zero} !== 17'd0)
            $display("FAIL reset_outputs got q=%0d r=%0d z=%b exp 0/0/0", quotient, remainder, div_by_zero);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        run_op(8'd100, 8'd7, 1'b1);
        total_cnt++;
        if (!r_ok || r_lat != 9) $display("FAIL basic_latency got %0d exp 9", r_lat);
        else pass_cnt++;
        total_cnt++;
        if ({r_q, r_r, r_z} !== {8'd14, 8'd2, 1'b0})
            $display("FAIL basic_100_7 got q=%0d r=%0d z=%b exp q=14 r=2 z=0", r_q, r_r, r_z);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL basic_back_to_idle got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
        else pass_cnt++;
    endtask

    task automatic test_div_zero();
        run_op(8'd5, 8'd0, 1'b0);
        total_cnt++;
        if (!r_ok || r_lat != 1) $display("FAIL zero_latency got %0d exp 1", r_lat);
        else pass_cnt++;
        total_cnt++;
        if ({r_q, r_r, r_z} !== {8'd255, 8'd5, 1'b1})
            $display("FAIL zero_5_0 got q=%0d r=%0d z=%b exp q=255 r=5 z=1", r_q, r_r, r_z);
        else pass_cnt++;
    endtask

    task automatic test_boundaries();
        logic [7:0] ta[6] = '{8'd255, 8'd3,  8'd0, 8'd255, 8'd254, 8'd128};
        logic [7:0] tb[6] = '{8'd1,   8'd10, 8'd9, 8'd255, 8'd255, 8'd2};
        logic [16:0] e;
        for (int i = 0; i < 6; i++) begin
            run_op(ta[i], tb[i], 1'b0);
            e = model(ta[i], tb[i]);
            total_cnt++;
            if (!r_ok || r_lat != 9 || {r_q, r_r, r_z} !== e)
                $display("FAIL boundary_%0d_%0d got q=%0d r=%0d z=%b lat=%0d exp q=%0d r=%0d z=%b lat=9",
                         ta[i], tb[i], r_q, r_r, r_z, r_lat, e[16:9], e[8:1], e[0]);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        bit seen = 1'b0;
        @(negedge clk);
        dividend  = 8'd200;
        divisor   = 8'd3;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (out_valid) seen = 1'b1;
            else @(negedge clk);
        end
        total_cnt++;
        if (!seen || {quotient, remainder, div_by_zero} !== {8'd66, 8'd2, 1'b0})
            $display("FAIL bp_result got valid=%b q=%0d r=%0d z=%b exp q=66 r=2 z=0", seen, quotient, remainder, div_by_zero);
        else pass_cnt++;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            dividend = 8'($urandom);
            divisor  = 8'($urandom);
            @(negedge clk);
            total_cnt++;
            if ({quotient, remainder, div_by_zero, out_valid, in_ready} !== {8'd66, 8'd2, 1'b0, 1'b1, 1'b0})
                $display("FAIL bp_hold_%0d got q=%0d r=%0d z=%b ov=%b ir=%b exp 66/2/0/1/0",
                         c, quotient, remainder, div_by_zero, out_valid, in_ready);
            else pass_cnt++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL bp_release got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
        else pass_cnt++;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_abort();
        bit leaked = 1'b0;
        @(negedge clk);
        dividend  = 8'd77;
        divisor   = 8'd4;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== 8'd0)
            $display("FAIL abort_async got ov=%b ir=%b q=%0d exp 0/1/0", out_valid, in_ready, quotient);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (out_valid) leaked = 1'b1;
        end
        total_cnt++;
        if (leaked) $display("FAIL abort_no_result got out_valid=1 exp 0");
        else pass_cnt++;
        run_op(8'd50, 8'd5, 1'b0);
        total_cnt++;
        if (!r_ok || {r_q, r_r, r_z} !== {8'd10, 8'd0, 1'b0})
            $display("FAIL abort_then_50_5 got q=%0d r=%0d z=%b exp q=10 r=0 z=0", r_q, r_r, r_z);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int got = 0;
        int cyc = 0;
        bit drv_fail = 1'b0;
        exp_q.delete();
        fork
            begin
                logic [7:0] a;
                logic [7:0] b;
                int n;
                for (int i = 0; i < 1000 && !drv_fail; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(negedge clk);
                        in_valid = 1'b0;
                    end
                    @(negedge clk);
                    a = 8'($urandom);
                    case ($urandom_range(0, 7))
                        0:       b = 8'd0;
                        1:       b = 8'd1;
                        2:       b = 8'($urandom_range(1, 15));
                        default: b = 8'($urandom);
                    endcase
                    dividend = a;
                    divisor  = b;
                    in_valid = 1'b1;
                    n = 0;
                    while (!in_ready && n < 200) begin
                        @(negedge clk);
                        n++;
                    end
                    if (!in_ready) drv_fail = 1'b1;
                    else exp_q.push_back(model(a, b));
                end
                @(negedge clk);
                in_valid = 1'b0;
            end
            begin
                logic [16:0] e;
                while (got < 1000 && cyc < 60000) begin
                    @(negedge clk);
                    cyc++;
                    out_ready = 1'($urandom_range(0, 1));
                    if (out_valid && out_ready) begin
                        total_cnt++;
                        if (exp_q.size() == 0) begin
                            $display("FAIL rand_extra_result got q=%0d r=%0d exp none", quotient, remainder);
                        end else begin
                            e = exp_q.pop_front();
                            if ({quotient, remainder, div_by_zero} !== e)
                                $display("FAIL rand_%0d got q=%0d r=%0d z=%b exp q=%0d r=%0d z=%b",
                                         got, quotient, remainder, div_by_zero, e[16:9], e[8:1], e[0]);
                            else pass_cnt++;
                        end
                        got++;
                    end
                end
            end
        join
        out_ready = 1'b0;
        total_cnt++;
        if (drv_fail || got != 1000)
            $display("FAIL rand_count got %0d results drv_stall=%b exp 1000", got, drv_fail);
        else pass_cnt++;
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL rand_leftover got %0d pending exp 0", exp_q.size());
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_boundaries();
        test_backpressure();
        test_reset_abort();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pe_divider.md
PE_DIVIDER -- requirements
Module: pe_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: dividend and divisor are valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept an operand pair.
REQ-006 The block SHALL have port dividend, input, WIDTH bits: unsigned numerator.
REQ-007 The block SHALL have port divisor, input, WIDTH bits: unsigned denominator.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 The block SHALL have port quotient, output, WIDTH bits: unsigned quotient.
REQ-011 The block SHALL have port remainder, output, WIDTH bits: unsigned remainder.
REQ-012 The block SHALL have port div_by_zero, output, 1 bit: the divisor was zero for the current result.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, CALC and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 Accept occurs when in_valid and in_ready are both 1 at a clock edge; the operands are then registered internally, and later input changes have no effect.
REQ-016 On accept with divisor != 0, the FSM SHALL go IDLE->CALC, load the step counter with WIDTH, and clear the partial remainder.
REQ-017 Each CALC cycle SHALL perform one restoring step:
- shift the partial remainder left, bringing in the next dividend MSB;
- trial-subtract the divisor at WIDTH+1 bits;
- if there is no borrow, keep the difference and set quotient bit 1;
- otherwise, restore and set quotient bit 0.
REQ-018 After WIDTH CALC cycles the FSM SHALL enter DONE, so out_valid rises exactly WIDTH+1 rising edges after the accepting edge.
REQ-019 On accept with divisor == 0, the FSM SHALL go directly to DONE on the next edge with quotient = all ones, remainder = dividend and div_by_zero = 1; the latency in this case is 1 edge.
REQ-020 In DONE, quotient, remainder and div_by_zero SHALL be held stable while out_ready = 0 (backpressure of any length).
REQ-021 DONE with out_ready = 1 SHALL go to IDLE at that edge; a new accept is possible no earlier than the following edge.
REQ-022 in_valid asserted during CALC or DONE SHALL be ignored and SHALL NOT corrupt the computation.
REQ-023 div_by_zero SHALL be 0 for every result whose divisor is nonzero.
REQ-024 Results SHALL satisfy dividend = quotient*divisor + remainder with remainder < divisor, for all nonzero divisors including divisor = 1 and divisor > dividend.

Reset
REQ-025 rst_n = 0 SHALL force, immediately and independent of clk:
- state IDLE;
- in_ready 1, out_valid 0;
- quotient, remainder, div_by_zero and the step counter 0.
REQ-026 Reset asserted during CALC or DONE SHALL abort the operation; no result is ever presented for an aborted operand pair.
REQ-027 After rst_n deasserts, the first accept is possible at the first rising edge.

Structure
REQ-028 A shared package pe_pkg SHALL hold the FSM state enumeration and the default operand-width constant (8).
REQ-029 The one-bit-per-cycle trial subtraction SHALL be a sub-module pe_sub_step: combinational, WIDTH+1 bits, outputs diff and borrow, instantiated once.
REQ-030 The top level SHALL hold the FSM, the counter, and the shift/restore registers; the RTL SHALL total 120-400 lines.

Verification
REQ-031 dividend=100, divisor=7, out_ready=1 -> out_valid 9 edges after accept; quotient=14, remainder=2, div_by_zero=0.
REQ-032 dividend=5, divisor=0 -> out_valid 1 edge after accept; quotient=255, remainder=5, div_by_zero=1.
REQ-033 Boundary cases:
- 255/1 -> quotient=255, remainder=0;
- 3/10 -> quotient=0, remainder=3;
- 0/9 -> quotient=0, remainder=0.
REQ-034 200/3 with out_ready=0 for 5 cycles in DONE -> quotient=66, remainder=2 held constant; in_ready=0 throughout; IDLE one edge after out_ready=1.
REQ-035 rst_n pulsed low during the 4th CALC cycle -> immediately out_valid=0, in_ready=1, quotient=0; a subsequent 50/5 gives quotient=10, remainder=0.
REQ-036 1000 random operand pairs with random in_valid/out_ready stalls -> every result matches the reference model, in order, with none dropped or duplicated.
